matmul_tile_scheduler: RTL and testbench

Sequences one full matrix-multiply command into a series of single-tile instructions for `control_unit`. The command multiplies an activation matrix of `rows` × (k_tiles·MUL_SIZE) by a weight matrix of (k_tiles·MUL_SIZE) × (n_tiles·MUL_SIZE).
- Loop order: n-tiles outer, k-tiles inner.
- For each tile the block computes the unified-buffer read base and the accumulate flag, fires `instruction`, and waits for `done_o`.
- It sits between the host/instruction front end and `control_unit`.

---
 rtl/matmul_tile_scheduler_pkg.sv | 9 +
 rtl/matmul_tile_scheduler_tile_index_counter.sv | 51 +++++
 rtl/matmul_tile_scheduler.sv | 153 +++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared types and sizing constants for the matmul tile scheduler and its index counter.
package matmul_tile_scheduler_pkg;
   localparam int MUL_SIZE   = 8;
   localparam int UB_ADDR_W  = 12;
   localparam int DIM_W      = 9;
   localparam int TILE_CNT_W = 6;

   typedef enum logic [1:0] {SCH_IDLE, SCH_ISSUE, SCH_WAIT, SCH_FIN} sched_state_t;
endpackage

// File: rtl/matmul_tile_scheduler_tile_index_counter.sv
// Nested k/n tile counter: k runs fastest and rolls into n; clr restarts at (0,0).
module tile_index_counter #(
   parameter int TILE_CNT_W = matmul_tile_scheduler_pkg::TILE_CNT_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  inc_i,
   input  logic [TILE_CNT_W-1:0] k_tiles_i,
   input  logic [TILE_CNT_W-1:0] n_tiles_i,
   output logic [TILE_CNT_W-1:0] k_idx_o,
   output logic [TILE_CNT_W-1:0] n_idx_o,
   output logic                  k_last_o,
   output logic                  n_last_o
);
   import matmul_tile_scheduler_pkg::*;

   logic [TILE_CNT_W-1:0] k_idx_q, k_idx_d;
   logic [TILE_CNT_W-1:0] n_idx_q, n_idx_d;

   assign k_last_o = (k_idx_q == k_tiles_i - TILE_CNT_W'(1));
   assign n_last_o = (n_idx_q == n_tiles_i - TILE_CNT_W'(1));
   assign k_idx_o  = k_idx_q;
   assign n_idx_o  = n_idx_q;

   always_comb begin
      k_idx_d = k_idx_q;
      n_idx_d = n_idx_q;
      if (clr_i) begin
         k_idx_d = '0;
         n_idx_d = '0;
      end else if (inc_i) begin
         if (k_last_o) begin
            k_idx_d = '0;
            n_idx_d = n_last_o ? '0 : n_idx_q + TILE_CNT_W'(1);
         end else begin
            k_idx_d = k_idx_q + TILE_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         k_idx_q <= '0;
         n_idx_q <= '0;
      end else begin
         k_idx_q <= k_idx_d;
         n_idx_q <= n_idx_d;
      end
   end
endmodule

// File: rtl/matmul_tile_scheduler.sv
// Breaks one matmul command into k_tiles*n_tiles single-tile instructions (n outer, k inner)
// for control_unit, tracking the UB read base and accumulate flag for each tile.
module matmul_tile_scheduler #(
   parameter int UB_ADDR_W  = matmul_tile_scheduler_pkg::UB_ADDR_W,
   parameter int DIM_W      = matmul_tile_scheduler_pkg::DIM_W,
   parameter int TILE_CNT_W = matmul_tile_scheduler_pkg::TILE_CNT_W
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [DIM_W-1:0]      cmd_rows_i,
   input  logic [DIM_W-1:0]      cmd_w_dim_i,
   input  logic [TILE_CNT_W-1:0] cmd_k_tiles_i,
   input  logic [TILE_CNT_W-1:0] cmd_n_tiles_i,
   input  logic [UB_ADDR_W-1:0]  cmd_ub_base_i,
   output logic                  instruction_o,
   output logic [DIM_W-1:0]      H_DIM_o,
   output logic [DIM_W-1:0]      W_DIM_o,
   output logic [UB_ADDR_W-1:0]  ub_start_addr_o,
   output logic                  tile_accumulate_o,
   input  logic                  tile_done_i,
   output logic                  out_tile_valid_o,
   output logic [TILE_CNT_W-1:0] out_n_idx_o,
   output logic                  busy_o,
   output logic                  cmd_done_o
);
   import matmul_tile_scheduler_pkg::*;

   sched_state_t          state_q, state_d;
   logic [DIM_W-1:0]      rows_q, rows_d, w_dim_q, w_dim_d;
   logic [TILE_CNT_W-1:0] k_tiles_q, k_tiles_d, n_tiles_q, n_tiles_d;
   logic [UB_ADDR_W-1:0]  base_q, base_d, addr_q, addr_d;
   logic [TILE_CNT_W-1:0] out_n_idx_q, out_n_idx_d;
   logic                  out_valid_q, out_valid_d;
   logic                  instr_q, instr_d, done_q, done_d, busy_q, busy_d, ready_q, ready_d;
   logic                  cnt_clr, cnt_inc, k_last, n_last;
   logic [TILE_CNT_W-1:0] k_idx, n_idx;

   tile_index_counter #(.TILE_CNT_W(TILE_CNT_W)) u_idx (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (cnt_clr),
      .inc_i     (cnt_inc),
      .k_tiles_i (k_tiles_q),
      .n_tiles_i (n_tiles_q),
      .k_idx_o   (k_idx),
      .n_idx_o   (n_idx),
      .k_last_o  (k_last),
      .n_last_o  (n_last)
   );

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      w_dim_d     = w_dim_q;
      k_tiles_d   = k_tiles_q;
      n_tiles_d   = n_tiles_q;
      base_d      = base_q;
      addr_d      = addr_q;
      out_n_idx_d = out_n_idx_q;
      out_valid_d = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      case (state_q)
         SCH_IDLE: begin
            if (cmd_valid_i) begin
               rows_d    = cmd_rows_i;
               w_dim_d   = cmd_w_dim_i;
               k_tiles_d = cmd_k_tiles_i;
               n_tiles_d = cmd_n_tiles_i;
               base_d    = cmd_ub_base_i;
               addr_d    = cmd_ub_base_i;
               cnt_clr   = 1'b1;
               if (cmd_rows_i == '0 || cmd_k_tiles_i == '0 || cmd_n_tiles_i == '0)
                  state_d = SCH_FIN;
               else
                  state_d = SCH_ISSUE;
            end
         end
         SCH_ISSUE: state_d = SCH_WAIT;
         SCH_WAIT: begin
            if (tile_done_i) begin
               cnt_inc = 1'b1;
               if (!k_last) begin
                  // Running add; wrap past the top of the UB is intentional.
                  addr_d  = addr_q + UB_ADDR_W'(rows_q);
                  state_d = SCH_ISSUE;
               end else begin
                  out_valid_d = 1'b1;
                  out_n_idx_d = n_idx;
                  if (!n_last) begin
                     addr_d  = base_q;
                     state_d = SCH_ISSUE;
                  end else begin
                     state_d = SCH_FIN;
                  end
               end
            end
         end
         SCH_FIN: state_d = SCH_IDLE;
         default: state_d = SCH_IDLE;
      endcase
      instr_d = (state_d == SCH_ISSUE);
      done_d  = (state_d == SCH_FIN);
      busy_d  = (state_d != SCH_IDLE);
      ready_d = (state_d == SCH_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= SCH_IDLE;
         rows_q      <= '0;
         w_dim_q     <= '0;
         k_tiles_q   <= '0;
         n_tiles_q   <= '0;
         base_q      <= '0;
         addr_q      <= '0;
         out_n_idx_q <= '0;
         out_valid_q <= 1'b0;
         instr_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         w_dim_q     <= w_dim_d;
         k_tiles_q   <= k_tiles_d;
         n_tiles_q   <= n_tiles_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         out_n_idx_q <= out_n_idx_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   assign cmd_ready_o       = ready_q;
   assign busy_o            = busy_q;
   assign instruction_o     = instr_q;
   assign cmd_done_o        = done_q;
   assign H_DIM_o           = rows_q;
   assign W_DIM_o           = w_dim_q;
   assign ub_start_addr_o   = addr_q;
   // k_idx only changes on an accepted done, so this is stable for the whole tile.
   assign tile_accumulate_o = (k_idx != '0);
   assign out_tile_valid_o  = out_valid_q;
   assign out_n_idx_o       = out_n_idx_q;
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed plus randomized command sequences checked against a plain-arithmetic tile model.
module tb_matmul_tile_scheduler;
   localparam int UB_ADDR_W  = 12;
   localparam int DIM_W      = 9;
   localparam int TILE_CNT_W = 6;

   logic                  clk_i = 1'b0;
   logic                  rst_i = 1'b1;
   logic                  cmd_valid_i = 1'b0;
   logic                  cmd_ready_o;
   logic [DIM_W-1:0]      cmd_rows_i = '0;
   logic [DIM_W-1:0]      cmd_w_dim_i = '0;
   logic [TILE_CNT_W-1:0] cmd_k_tiles_i = '0;
   logic [TILE_CNT_W-1:0] cmd_n_tiles_i = '0;
   logic [UB_ADDR_W-1:0]  cmd_ub_base_i = '0;
   logic                  instruction_o;
   logic [DIM_W-1:0]      H_DIM_o;
   logic [DIM_W-1:0]      W_DIM_o;
   logic [UB_ADDR_W-1:0]  ub_start_addr_o;
   logic                  tile_accumulate_o;
   logic                  tile_done_i = 1'b0;
   logic                  out_tile_valid_o;
   logic [TILE_CNT_W-1:0] out_n_idx_o;
   logic                  busy_o;
   logic                  cmd_done_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   matmul_tile_scheduler dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .cmd_valid_i       (cmd_valid_i),
      .cmd_ready_o       (cmd_ready_o),
      .cmd_rows_i        (cmd_rows_i),
      .cmd_w_dim_i       (cmd_w_dim_i),
      .cmd_k_tiles_i     (cmd_k_tiles_i),
      .cmd_n_tiles_i     (cmd_n_tiles_i),
      .cmd_ub_base_i     (cmd_ub_base_i),
      .instruction_o     (instruction_o),
      .H_DIM_o           (H_DIM_o),
      .W_DIM_o           (W_DIM_o),
      .ub_start_addr_o   (ub_start_addr_o),
      .tile_accumulate_o (tile_accumulate_o),
      .tile_done_i       (tile_done_i),
      .out_tile_valid_o  (out_tile_valid_o),
      .out_n_idx_o       (out_n_idx_o),
      .busy_o            (busy_o),
      .cmd_done_o        (cmd_done_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, 32'(cmd_ready_o), 1);
      chk({tag, "_busy"}, 32'(busy_o), 0);
      chk({tag, "_instr"}, 32'(instruction_o), 0);
      chk({tag, "_done"}, 32'(cmd_done_o), 0);
      chk({tag, "_otv"}, 32'(out_tile_valid_o), 0);
   endtask

   // One command end to end. hold keeps cmd_valid_i high with junk fields while busy;
   // stray raises tile_done_i during every ISSUE cycle.
   task automatic run_cmd(input int rows, input int w, input int k, input int n, input int base,
                          input bit hold, input bit stray);
      int exp_addr;
      int d;
      chk("pre_ready", 32'(cmd_ready_o), 1);
      cmd_rows_i    = DIM_W'(rows);
      cmd_w_dim_i   = DIM_W'(w);
      cmd_k_tiles_i = TILE_CNT_W'(k);
      cmd_n_tiles_i = TILE_CNT_W'(n);
      cmd_ub_base_i = UB_ADDR_W'(base);
      cmd_valid_i   = 1'b1;
      tick();
      if (hold) begin
         cmd_rows_i    = DIM_W'($urandom);
         cmd_w_dim_i   = DIM_W'($urandom);
         cmd_k_tiles_i = TILE_CNT_W'($urandom);
         cmd_n_tiles_i = TILE_CNT_W'($urandom);
         cmd_ub_base_i = UB_ADDR_W'($urandom);
      end else begin
         cmd_valid_i = 1'b0;
      end
      if (rows == 0 || k == 0 || n == 0) begin
         chk("zero_done", 32'(cmd_done_o), 1);
         chk("zero_instr", 32'(instruction_o), 0);
         chk("zero_otv", 32'(out_tile_valid_o), 0);
         cmd_valid_i = 1'b0;
         tick();
         chk_idle("zero_after");
         $display("cmd rows=%0d k=%0d n=%0d base=0x%03h: zero-size, done only", rows, k, n, base);
         return;
      end
      for (int ni = 0; ni < n; ni++) begin
         for (int ki = 0; ki < k; ki++) begin
            exp_addr = (base + ki * rows) % 4096;
            chk("issue_instr", 32'(instruction_o), 1);
            chk("issue_addr", 32'(ub_start_addr_o), 32'(exp_addr));
            chk("issue_acc", 32'(tile_accumulate_o), 32'(ki != 0));
            chk("issue_hdim", 32'(H_DIM_o), 32'(rows % 512));
            chk("issue_wdim", 32'(W_DIM_o), 32'(w % 512));
            chk("issue_busy", 32'(busy_o), 1);
            chk("issue_done", 32'(cmd_done_o), 0);
            chk("issue_otv", 32'(out_tile_valid_o), 32'(ki == 0 && ni > 0));
            if (ki == 0 && ni > 0) chk("issue_nidx", 32'(out_n_idx_o), 32'(ni - 1));
            $display("tile n=%0d k=%0d addr=0x%03h acc=%0d", ni, ki, ub_start_addr_o, tile_accumulate_o);
            tile_done_i = stray;
            d = int'($urandom_range(1, 5));
            for (int j = 0; j < d; j++) begin
               tick();
               tile_done_i = 1'b0;
               chk("wait_instr", 32'(instruction_o), 0);
               chk("wait_addr", 32'(ub_start_addr_o), 32'(exp_addr));
               chk("wait_acc", 32'(tile_accumulate_o), 32'(ki != 0));
               chk("wait_otv", 32'(out_tile_valid_o), 0);
               chk("wait_busy", 32'(busy_o), 1);
            end
            tile_done_i = 1'b1;
            tick();
            tile_done_i = 1'b0;
         end
      end
      chk("fin_otv", 32'(out_tile_valid_o), 1);
      chk("fin_nidx", 32'(out_n_idx_o), 32'(n - 1));
      chk("fin_done", 32'(cmd_done_o), 1);
      chk("fin_instr", 32'(instruction_o), 0);
      cmd_valid_i = 1'b0;
      tick();
      chk_idle("after_fin");
      $display("cmd rows=%0d k=%0d n=%0d base=0x%03h: %0d tiles complete", rows, k, n, base, k * n);
   endtask

   initial begin
      // Reset then idle
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      chk_idle("reset");
      chk("reset_hdim", 32'(H_DIM_o), 0);
      chk("reset_wdim", 32'(W_DIM_o), 0);
      chk("reset_addr", 32'(ub_start_addr_o), 0);
      chk("reset_acc", 32'(tile_accumulate_o), 0);
      chk("reset_nidx", 32'(out_n_idx_o), 0);
      $display("reset released");

      // Stray done in IDLE must not start anything
      tile_done_i = 1'b1;
      tick();
      tick();
      tile_done_i = 1'b0;
      chk_idle("stray_idle");
      tick();
      chk_idle("stray_idle2");
      $display("stray tile_done in idle ignored");

      run_cmd(8, 8, 1, 1, 'h010, 1'b0, 1'b0);
      run_cmd(16, 8, 3, 2, 'h100, 1'b0, 1'b0);
      run_cmd(16, 8, 2, 1, 'hFF8, 1'b0, 1'b0);
      run_cmd(16, 8, 0, 2, 'h040, 1'b0, 1'b0);
      run_cmd(12, 5, 2, 2, 'h200, 1'b1, 1'b1);

      // Reset during the WAIT of the second tile
      cmd_rows_i = 9'd16; cmd_w_dim_i = 9'd8; cmd_k_tiles_i = 6'd3; cmd_n_tiles_i = 6'd2;
      cmd_ub_base_i = 12'h100; cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      chk("rst_t1_instr", 32'(instruction_o), 1);
      tick();
      tick();
      tile_done_i = 1'b1;
      tick();
      tile_done_i = 1'b0;
      chk("rst_t2_instr", 32'(instruction_o), 1);
      chk("rst_t2_addr", 32'(ub_start_addr_o), 'h110);
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk_idle("mid_reset");
      chk("mid_reset_addr", 32'(ub_start_addr_o), 0);
      chk("mid_reset_acc", 32'(tile_accumulate_o), 0);
      tick();
      chk_idle("mid_reset2");
      $display("reset mid-command aborted cleanly");
      run_cmd(16, 8, 3, 2, 'h100, 1'b0, 1'b0);

      // Randomized commands
      for (int r = 0; r < 8; r++) begin
         run_cmd(int'($urandom_range(0, 300)), int'($urandom_range(1, 511)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
